// File: rtl/best_time_tracker.sv
// Captures the final BCD reaction time at the end of each run and keeps the lowest valid time seen.
// Optional BEST_TIME_LAST_EN adds last/last_valid outputs exposing every captured time.
module best_time_tracker #(
    parameter int unsigned DIGITS          = 6,
    parameter bit          BEST_INIT_NINES = 1'b1
) (
    input  logic                cin,
    input  logic                R,
    input  logic                clr_best,
    input  logic                run,
    input  logic [4*DIGITS-1:0] elapsed,
    output logic [4*DIGITS-1:0] best,
    output logic                best_valid,
    output logic                new_record,
    output logic                reject,
    output logic                busy
`ifdef BEST_TIME_LAST_EN
    ,
    output logic [4*DIGITS-1:0] last,
    output logic                last_valid
`endif
);

    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [W-1:0]  BEST_RST = BEST_INIT_NINES ? {DIGITS{4'h9}} : W'(0);
    localparam logic [IW-1:0] IDX_TOP  = IW'(DIGITS - 1);

    typedef enum logic [2:0] {IDLE, TIMING, CHECK, COMPARE, WRITE} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    cap_q;
    logic [IW-1:0]   idx_q;
    logic            run_q;
    logic            run_ok_q;
    logic            run_rise;
    logic            cap_bad;
    logic            cap_reject;
    logic [3:0]      cap_nib;
    logic [3:0]      best_nib;
    logic            load_cap, load_best, set_idx, dec_idx, reject_d, record_d;

    // run_ok blocks a run that is already high when reset releases from looking like a rise
    assign run_rise = run & ~run_q & run_ok_q;

    always_comb begin
        cap_bad = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (cap_q[4*i +: 4] > 4'd9) cap_bad = 1'b1;
        end
    end

    assign cap_reject = cap_bad | (cap_q == W'(0));
    assign cap_nib    = cap_q[idx_q*4 +: 4];
    assign best_nib   = best[idx_q*4 +: 4];

    // State register
    always_ff @(posedge cin or posedge R) begin
        if (R) state_q <= IDLE;
        else   state_q <= state_d;
    end

    // Next state and datapath strobes; clr_best overrides everything
    always_comb begin
        state_d   = state_q;
        load_cap  = 1'b0;
        load_best = 1'b0;
        set_idx   = 1'b0;
        dec_idx   = 1'b0;
        reject_d  = 1'b0;
        record_d  = 1'b0;
        case (state_q)
            IDLE: if (run_rise) state_d = TIMING;
            TIMING: begin
                if (!run) begin
                    load_cap = 1'b1;
                    state_d  = CHECK;
                end
            end
            CHECK: begin
                if (cap_reject) begin
                    reject_d = 1'b1;
                    state_d  = IDLE;
                end else if (!best_valid) begin
                    state_d = WRITE;
                end else begin
                    set_idx = 1'b1;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (cap_nib < best_nib)      state_d = WRITE;
                else if (cap_nib > best_nib) state_d = IDLE;
                else if (idx_q != '0)        dec_idx = 1'b1;
                else                         state_d = IDLE;
            end
            WRITE: begin
                load_best = 1'b1;
                record_d  = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (clr_best) begin
            state_d   = IDLE;
            load_cap  = 1'b0;
            load_best = 1'b0;
            set_idx   = 1'b0;
            dec_idx   = 1'b0;
            reject_d  = 1'b0;
            record_d  = 1'b0;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge cin or posedge R) begin
        if (R) begin
            run_q      <= 1'b0;
            run_ok_q   <= 1'b0;
            cap_q      <= '0;
            idx_q      <= '0;
            best       <= BEST_RST;
            best_valid <= 1'b0;
            new_record <= 1'b0;
            reject     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            run_q      <= run;
            run_ok_q   <= 1'b1;
            new_record <= record_d;
            reject     <= reject_d;
            busy       <= (state_d != IDLE);
            if (load_cap) cap_q <= elapsed;
            if (set_idx)      idx_q <= IDX_TOP;
            else if (dec_idx) idx_q <= idx_q - IW'(1);
            if (clr_best) begin
                best       <= BEST_RST;
                best_valid <= 1'b0;
            end else if (load_best) begin
                best       <= cap_q;
                best_valid <= 1'b1;
            end
        end
    end

`ifdef BEST_TIME_LAST_EN
    logic check_en;

    assign check_en = (state_q == CHECK) && !clr_best;

    // Every capture is exposed, rejected ones flagged invalid; clr_best leaves these alone
    always_ff @(posedge cin or posedge R) begin
        if (R) begin
            last       <= '0;
            last_valid <= 1'b0;
        end else if (check_en) begin
            last       <= cap_q;
            last_valid <= ~cap_reject;
        end
    end
`endif

endmodule

// File: tb/tb_best_time_tracker.sv
// Scoreboard bench for best_time_tracker: stimulus queues expected pulses, a monitor pops and checks them.
module tb_best_time_tracker;

    localparam logic [23:0] NINES = 24'h999999;

    logic        cin;
    logic        R;
    logic        clr_best;
    logic        run;
    logic [23:0] elapsed;
    logic [23:0] best;
    logic        best_valid;
    logic        new_record;
    logic        reject;
    logic        busy;

    typedef struct {
        int          kind;   // 1 = new_record, 2 = reject
        logic [23:0] val;
        int          cyc;
    } ev_t;

    ev_t         exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [23:0] exp_best;
    logic        exp_bv;

    best_time_tracker #(.DIGITS(6), .BEST_INIT_NINES(1'b1)) dut (
        .cin        (cin),
        .R          (R),
        .clr_best   (clr_best),
        .run        (run),
        .elapsed    (elapsed),
        .best       (best),
        .best_valid (best_valid),
        .new_record (new_record),
        .reject     (reject),
        .busy       (busy)
    );

    initial cin = 1'b0;
    always #5 cin = ~cin;

    always @(posedge cin) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every pulse must match the head of the expected queue
    always @(negedge cin) begin
        if (!R && (new_record || reject)) begin
            ev_t e;
            int  got;
            got = new_record ? (reject ? 3 : 1) : 2;
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 32'(got), 32'(0));
            end else begin
                e = exp_q.pop_front();
                chk("pulse_kind",  32'(got), 32'(e.kind));
                chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
                chk("pulse_best",  32'(best), 32'(e.val));
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 30; i++) begin
            @(negedge cin);
            if (!busy) break;
        end
        chk("idle_reached", 32'(busy), 32'(0));
    endtask

    // One run: kind 0 = no pulse, 1 = record, 2 = reject; lat = edges after E0
    task automatic do_run(input logic [23:0] val, input int kind, input int lat);
        ev_t e;
        @(negedge cin);
        run = 1'b1;
        elapsed = 24'h123456;
        @(negedge cin);
        chk("busy_timing", 32'(busy), 32'(1));
        repeat (2) @(negedge cin);
        elapsed = val;
        run = 1'b0;
        if (kind != 0) begin
            e.kind = kind;
            e.val  = (kind == 1) ? val : exp_best;
            e.cyc  = cyc + 1 + lat;
            exp_q.push_back(e);
            if (kind == 1) begin
                exp_best = val;
                exp_bv   = 1'b1;
            end
        end
        wait_idle();
        repeat (2) @(negedge cin);
        chk("best_after_run",  32'(best), 32'(exp_best));
        chk("valid_after_run", 32'(best_valid), 32'(exp_bv));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        R        = 1'b1;
        clr_best = 1'b0;
        run      = 1'b0;
        elapsed  = '0;
        exp_best = NINES;
        exp_bv   = 1'b0;
        repeat (3) @(negedge cin);
        chk("rst_best",       32'(best), 32'(NINES));
        chk("rst_best_valid", 32'(best_valid), 32'(0));
        chk("rst_new_record", 32'(new_record), 32'(0));
        chk("rst_reject",     32'(reject), 32'(0));
        chk("rst_busy",       32'(busy), 32'(0));
        R = 1'b0;
        repeat (2) @(negedge cin);

        do_run(24'h000245, 1, 2);      // first record
        do_run(24'h000231, 1, 7);      // k = 4
        do_run(24'h000231, 0, 0);      // tie
        do_run(24'h000400, 0, 0);      // slower
        do_run(24'h000000, 2, 1);      // zero
        do_run(24'h0A0100, 2, 1);      // invalid nibble
        do_run(24'h000199, 1, 6);      // k = 3

        // clr_best during COMPARE of 000198 vs 000199
        @(negedge cin);
        run = 1'b1;
        repeat (3) @(negedge cin);
        elapsed = 24'h000198;
        run = 1'b0;
        repeat (4) @(negedge cin);     // now after E0+3, still comparing
        chk("busy_compare", 32'(busy), 32'(1));
        clr_best = 1'b1;
        @(negedge cin);
        clr_best = 1'b0;
        exp_best = NINES;
        exp_bv   = 1'b0;
        chk("clr_busy",       32'(busy), 32'(0));
        chk("clr_best_val",   32'(best), 32'(NINES));
        chk("clr_best_valid", 32'(best_valid), 32'(0));
        repeat (8) @(negedge cin);
        chk("clr_best_hold",  32'(best), 32'(NINES));

        do_run(24'h000500, 1, 2);      // first record after clear

        // async reset while TIMING
        @(negedge cin);
        run = 1'b1;
        @(negedge cin);
        chk("busy_before_r", 32'(busy), 32'(1));
        #2 R = 1'b1;
        #1;
        exp_best = NINES;
        exp_bv   = 1'b0;
        chk("ar_busy",       32'(busy), 32'(0));
        chk("ar_best",       32'(best), 32'(NINES));
        chk("ar_best_valid", 32'(best_valid), 32'(0));
        @(negedge cin);
        R = 1'b0;
        repeat (4) @(negedge cin);
        chk("no_rise_after_reset", 32'(busy), 32'(0));
        run = 1'b0;
        @(negedge cin);

        do_run(24'h000777, 1, 2);      // tracked normally after reset

        repeat (4) @(negedge cin);
        chk("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/best_time_tracker.md
Name: best_time_tracker

Overview:
- Sits directly downstream of the six-digit BCD reaction counter chain.
- Consumes the 24-bit elapsed-time word and the run/activation level, and captures the final time when a run ends.
- Compares the captured time digit-serially against the stored best (lowest) time and updates the record on a strictly faster run.
- Feeds best[] to the high-score selector/display mux; one instance per game mode.

Parameters:
DIGITS, 6, number of BCD digits; data width is 4*DIGITS
BEST_INIT_NINES, 1, 1: best resets to all 9s; 0: best resets to all 0s

Ports:
cin  input  1  system clock, rising edge
R  input  1  asynchronous active-high reset
clr_best  input  1  synchronous clear of stored record, held 1+ cycles
run  input  1  activation level from mode FSM; high while counter is timing
elapsed  input  4*DIGITS  BCD counter value, digit 0 = least significant nibble
best  output  4*DIGITS  stored best time, BCD
best_valid  output  1  1 once any run has been recorded
new_record  output  1  one-cycle pulse when best is loaded
reject  output  1  one-cycle pulse: captured time is zero or not valid BCD
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (R=1, asynchronous) puts the FSM in IDLE and clears the internal run_q register.
  - best = all 9s (or all 0s per BEST_INIT_NINES).
  - best_valid = 0, new_record = 0, reject = 0, capture register = 0.
- Rise of run is detected by comparing against registered run_q.
- States: IDLE, TIMING, CHECK, COMPARE, WRITE.
- IDLE: on a run rise (run=1, run_q=0), go to TIMING. A run already high on leaving reset is not a rise.
- TIMING: on the edge that samples run=0, load elapsed into cap and go to CHECK.
- CHECK (1 cycle):
  - If any cap nibble > 9, or cap == 0, pulse reject and return to IDLE.
  - Else if best_valid == 0, go to WRITE.
  - Else set idx = DIGITS-1 and go to COMPARE.
- COMPARE (1 cycle per digit, MSB first):
  - cap[idx] < best[idx]: go to WRITE.
  - cap[idx] > best[idx]: go to IDLE with no update.
  - Equal and idx > 0: decrement idx and stay in COMPARE.
  - Equal and idx == 0 (tie): go to IDLE with no update.
- WRITE: on the exiting edge, best <= cap, best_valid <= 1, new_record high for exactly one cycle, then go to IDLE.
- Latency, counted from edge E0 that samples run low:
  - No prior record: best loads at E0+2.
  - Otherwise: best loads at E0+3+k, where k is the number of equal leading digits.
- new_record and reject are registered, mutually exclusive, and never high in the same cycle.
- run rises while busy in CHECK/COMPARE/WRITE are ignored; that run is not tracked. In TIMING, run glitching high again has no effect.
- clr_best has highest synchronous priority in any state:
  - best = reset value, best_valid = 0, FSM to IDLE.
  - Aborts any evaluation; no new_record or reject pulse.
- The 24-bit word is treated as pure BCD with no binary arithmetic. Any overflow/wrap of the counter is the counter's responsibility; a wrapped value is compared as-is.

Optional Feature:
- Macro: BEST_TIME_LAST_EN.
- Defined:
  - Adds output last[4*DIGITS] and output last_valid[1].
  - last is loaded with cap at the CHECK state for every capture, including rejected ones.
  - last_valid = 1 for accepted captures, 0 for rejected ones.
  - Both are cleared by R; clr_best does not clear them.
- Undefined: neither port exists; all other behaviour is identical.

Test Plan:
1. Reset, then run pulse with elapsed=000245 at fall -> best=000245 at E0+2, best_valid=1, new_record one cycle.
2. Best=000245; run ends at 000231 -> k=4, best=000231 at E0+7, new_record=1.
3. Best=000231; run ends at 000231 (tie), then at 000400 -> no update, no new_record, busy drops after evaluation.
4. Run ends at 000000, then at 0A0100 (invalid nibble) -> reject pulse each time, best unchanged.
5. clr_best asserted mid-COMPARE -> IDLE next cycle, best=999999, best_valid=0, no pulses.
6. Assert R asynchronously during TIMING -> immediate IDLE with reset outputs; run held high afterward is not a rise; a new rise is tracked normally.
